// File: rtl/sync_fifo_ext.sv
// sync_fifo_ext: parametrised single-clock FIFO with count, thresholds, flush and sticky errors; define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
module sync_fifo_ext #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       en_w,
  input  logic                       en_r,
  output logic [WIDTH-1:0]           data_o,
  output logic                       ack_w,
  output logic                       ack_r,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_ext: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_ext: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_ext: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt_nxt;
  logic             ra, wa;

  // flush wins over both requests, so neither side is accepted on a clr cycle
  assign ra = en_r & ~empty & ~clr;
  assign wa = en_w & (~full | ra) & ~clr;

  // occupancy after this edge; flags are registered from it so they match count
  always_comb
    cnt_nxt = clr ? '0 : (wa && !ra) ? count + 1'b1 : (ra && !wa) ? count - 1'b1 : count;

  // storage is not reset or flushed; only the pointers define valid contents
  always_ff @(posedge clk)
    if (wa) mem[wr_ptr] <= data_i;

  // pointers, occupancy, flags, write ack and sticky error state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      ack_w        <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= clr ? '0 : wa ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr       <= clr ? '0 : ra ? rd_ptr + 1'b1 : rd_ptr;
      count        <= cnt_nxt;
      full         <= cnt_nxt == DEPTH_C;
      empty        <= cnt_nxt == '0;
      almost_full  <= cnt_nxt >= AF_C;
      almost_empty <= cnt_nxt <= AE_C;
      ack_w        <= wa;
      overflow     <= ~clr & (overflow | (en_w & ~wa));
      underflow    <= ~clr & (underflow | (en_r & empty));
    end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_o = empty ? '0 : mem[rd_ptr];
  assign ack_r  = ra;
`else
  // registered read port: data_o is captured on the accepting edge and held otherwise
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_o <= '0;
      ack_r  <= 1'b0;
    end else begin
      ack_r <= ra;
      if (ra) data_o <= mem[rd_ptr];
    end
`endif
endmodule

// File: tb/tb_sync_fifo_ext.sv
// tb_sync_fifo_ext: directed self-checking bench for sync_fifo_ext (both read modes)
module tb_sync_fifo_ext;
  logic       clk = 0, rst = 1, clr = 0, en_w = 0, en_r = 0;
  logic [7:0] data_i = 0, data_o;
  logic       ack_w, ack_r, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  logic       pre_ack_r, rd_ack;
  logic [7:0] pre_data, rd_data;
  int         checks = 0, errors = 0;

  sync_fifo_ext dut (
    .clk(clk), .rst(rst), .clr(clr), .data_i(data_i), .en_w(en_w), .en_r(en_r),
    .data_o(data_o), .ack_w(ack_w), .ack_r(ack_r), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // one clock with the given requests; rd_ack/rd_data hold the read result for the active mode
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    en_w = w; en_r = r; data_i = d;
    #1;
    pre_ack_r = ack_r; pre_data = data_o;
    @(posedge clk); #1;
`ifdef SYNC_FIFO_FWFT_EN
    rd_ack = pre_ack_r; rd_data = pre_data;
`else
    rd_ack = ack_r; rd_data = data_o;
`endif
    en_w = 0; en_r = 0;
  endtask

  task automatic do_clr();
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
  endtask

  task automatic test_reset();
    cyc(1, 0, 8'h11);
    cyc(1, 0, 8'h22);
    cyc(1, 1, 8'h33);
    #2 rst = 1;
    #1;
    checks++; if (empty !== 1'b1 || almost_empty !== 1'b1 || count !== 5'd0) begin errors++;
      $display("FAIL reset_state empty=%b ae=%b count=%0d required 1 1 0", empty, almost_empty, count); end
    checks++; if (ack_w !== 1'b0 || ack_r !== 1'b0 || data_o !== 8'h00) begin errors++;
      $display("FAIL reset_acks ack_w=%b ack_r=%b data_o=%h required 0 0 00", ack_w, ack_r, data_o); end
    checks++; if (full !== 1'b0 || almost_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin errors++;
      $display("FAIL reset_flags full=%b af=%b ovf=%b unf=%b required 0 0 0 0", full, almost_full, overflow, underflow); end
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 8'(i));
      checks++; if (ack_w !== 1'b1 || count !== 5'(i + 1)) begin errors++;
        $display("FAIL fill_%0d ack_w=%b count=%0d required 1 %0d", i, ack_w, count, i + 1); end
      checks++; if (full !== (i == 15) || almost_full !== (i + 1 >= 14) || almost_empty !== (i + 1 <= 2)) begin errors++;
        $display("FAIL fill_flags_%0d full=%b af=%b ae=%b", i, full, almost_full, almost_empty); end
    end
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 8'h00);
      checks++; if (rd_ack !== 1'b1 || rd_data !== 8'(i) || count !== 5'(15 - i)) begin errors++;
        $display("FAIL drain_%0d ack=%b data=%h count=%0d required 1 %h %0d", i, rd_ack, rd_data, count, i, 15 - i); end
    end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++;
      $display("FAIL drain_empty empty=%b full=%b required 1 0", empty, full); end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'h20 + 8'(i));
    cyc(1, 1, 8'h55);
    checks++; if (ack_w !== 1'b1 || rd_ack !== 1'b1 || rd_data !== 8'h20) begin errors++;
      $display("FAIL full_rw ack_w=%b ack_r=%b data=%h required 1 1 20", ack_w, rd_ack, rd_data); end
    checks++; if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin errors++;
      $display("FAIL full_rw_state count=%0d full=%b ovf=%b required 16 1 0", count, full, overflow); end
    for (int i = 1; i < 17; i++) begin
      cyc(0, 1, 8'h00);
      checks++; if (rd_data !== ((i == 16) ? 8'h55 : 8'h20 + 8'(i))) begin errors++;
        $display("FAIL full_rw_drain_%0d data=%h", i, rd_data); end
    end
    cyc(1, 1, 8'h66);
    checks++; if (ack_w !== 1'b1 || rd_ack !== 1'b0 || count !== 5'd1 || underflow !== 1'b1) begin errors++;
      $display("FAIL empty_rw ack_w=%b ack_r=%b count=%0d unf=%b required 1 0 1 1", ack_w, rd_ack, count, underflow); end
`ifdef SYNC_FIFO_FWFT_EN
    checks++; if (data_o !== 8'h66) begin errors++; $display("FAIL head_shown data_o=%h required 66", data_o); end
`else
    checks++; if (data_o !== 8'h55) begin errors++; $display("FAIL data_hold data_o=%h required 55", data_o); end
`endif
    do_clr();
    checks++; if (count !== 5'd0 || empty !== 1'b1 || underflow !== 1'b0) begin errors++;
      $display("FAIL clr_underflow count=%0d empty=%b unf=%b required 0 1 0", count, empty, underflow); end
`ifdef SYNC_FIFO_FWFT_EN
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL empty_data data_o=%h required 00", data_o); end
`else
    checks++; if (data_o !== 8'h55) begin errors++; $display("FAIL clr_data_hold data_o=%h required 55", data_o); end
`endif
  endtask

  task automatic test_errors();
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'h30 + 8'(i));
    cyc(1, 0, 8'h77);
    checks++; if (ack_w !== 1'b0 || overflow !== 1'b1 || count !== 5'd16) begin errors++;
      $display("FAIL overflow ack_w=%b ovf=%b count=%0d required 0 1 16", ack_w, overflow, count); end
    cyc(0, 0, 8'h00);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky ovf=%b required 1", overflow); end
    clr = 1;
    cyc(1, 1, 8'h88);
    clr = 0;
    checks++; if (count !== 5'd0 || overflow !== 1'b0 || ack_w !== 1'b0 || rd_ack !== 1'b0) begin errors++;
      $display("FAIL clr count=%0d ovf=%b ack_w=%b ack_r=%b required 0 0 0 0", count, overflow, ack_w, rd_ack); end
    cyc(0, 1, 8'h00);
    checks++; if (rd_ack !== 1'b0 || underflow !== 1'b1 || empty !== 1'b1) begin errors++;
      $display("FAIL read_after_clr ack_r=%b unf=%b empty=%b required 0 1 1", rd_ack, underflow, empty); end
    do_clr();
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] nxt = 8'h40;
    for (int i = 0; i < 15; i++) begin cyc(1, 0, nxt); q.push_back(nxt); nxt++; end
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) begin
        cyc(1, 0, nxt); q.push_back(nxt); nxt++;
        checks++; if (ack_w !== 1'b1 || count !== 5'd16) begin errors++;
          $display("FAIL wrap_w_%0d ack_w=%b count=%0d required 1 16", k, ack_w, count); end
      end else begin
        cyc(0, 1, 8'h00);
        checks++; if (rd_ack !== 1'b1 || rd_data !== q[0] || count !== 5'd15) begin errors++;
          $display("FAIL wrap_r_%0d ack=%b data=%h count=%0d required 1 %h 15", k, rd_ack, rd_data, count, q[0]); end
        void'(q.pop_front());
      end
    end
    while (q.size() > 0) begin
      cyc(0, 1, 8'h00);
      checks++; if (rd_data !== q[0]) begin errors++;
        $display("FAIL wrap_drain data=%h required %h", rd_data, q[0]); end
      void'(q.pop_front());
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty empty=%b required 1", empty); end
  endtask

  initial begin
    #12 rst = 0;
    @(posedge clk); #1;
    test_reset();
    test_fill_drain();
    test_boundary();
    test_errors();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
